// File: rtl/rcc_pkg.sv
// -----------------------------------------------------------------------------
// rcc_pkg
// Shared types and constants for the RCC power-domain reset sequencer.
//   - rcc_state_t      : sequencer states HOLD..RUN
//   - RCC_CAUSE_*      : reset-cause bit encodings
//   - rcc_cnt_width()  : down-counter width for the longest sequence phase
//   - rcc_decode()     : per-state {dom_rst_n, dom_clk_en, busy}
// -----------------------------------------------------------------------------
package rcc_pkg;

    typedef enum logic [2:0] {
        HOLD    = 3'd0,
        ASSERT  = 3'd1,
        GATE    = 3'd2,
        RELEASE = 3'd3,
        RUN     = 3'd4
    } rcc_state_t;

    localparam logic [1:0] RCC_CAUSE_NONE = 2'b00;
    localparam logic [1:0] RCC_CAUSE_PWR  = 2'b01;
    localparam logic [1:0] RCC_CAUSE_SW   = 2'b10;

    // clog2 of the larger duration, never narrower than one bit.
    function automatic int unsigned rcc_cnt_width(input int unsigned a,
                                                  input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

    // Output pattern for a state: {rst_n, clk_en, busy}.
    function automatic logic [2:0] rcc_decode(input rcc_state_t s);
        logic [2:0] o;
        o = 3'b001;
        unique case (s)
            HOLD:    o = 3'b001;
            ASSERT:  o = 3'b011;
            GATE:    o = 3'b001;
            RELEASE: o = 3'b101;
            RUN:     o = 3'b110;
            default: o = 3'b001;
        endcase
        return o;
    endfunction

endpackage : rcc_pkg

// File: rtl/rcc_dly_cnt.sv
// -----------------------------------------------------------------------------
// rcc_dly_cnt
// Loadable, saturating down-counter used for the sequence phase timing and
// for the power-ready timeout.
//   clk          in  : clock
//   rst          in  : synchronous active-high reset (counter <= RST_VAL)
//   i_load       in  : load i_load_val (wins over i_dec)
//   i_load_val   in  : value to load
//   i_dec        in  : decrement while nonzero, holds at zero
//   o_zero_c     out : counter equals zero (combinational from the register)
// -----------------------------------------------------------------------------
module rcc_dly_cnt #(
    parameter int unsigned   W       = 4,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero_c
);

    logic [W-1:0] r_cnt;

    // Counter register: load has priority, decrement never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= RST_VAL;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero_c = (r_cnt == '0);

endmodule : rcc_dly_cnt

// File: rtl/rcc_dom_rst_seq.sv
// -----------------------------------------------------------------------------
// rcc_dom_rst_seq
// Power-domain reset sequencer. Converts power-ready or a software reset
// request into: reset asserted with clock running, clock gated, reset
// released, clock re-enabled. Keeps a sticky reset flag and cause.
//
// Optional feature macro: RCC_RST_SEQ_TIMEOUT_EN
//   defined   : pwr_timeout sets (sticky) after PWR_TIMEOUT consecutive HOLD
//               cycles; cleared by flag_clr or rst.
//   undefined : pwr_timeout is constant 0.
//
// Ports:
//   clk          in  : domain clock
//   rst          in  : synchronous active-high reset
//   pwr_rdy      in  : domain power good (synchronous to clk)
//   sw_rst_req   in  : single-cycle software reset request
//   flag_clr     in  : single-cycle clear of rst_flag / rst_cause / pwr_timeout
//   dom_rst_n    out : domain reset, active-low
//   dom_clk_en   out : domain clock enable
//   busy         out : sequence in progress (state != RUN)
//   rst_flag     out : sticky, a domain reset occurred
//   rst_cause    out : 01 power, 10 software, 11 both since last clear
//   pwr_timeout  out : sticky power-ready timeout
// -----------------------------------------------------------------------------
module rcc_dom_rst_seq
    import rcc_pkg::*;
#(
    parameter int unsigned RST_DURATION             = 10,
    parameter int unsigned CLK_ON_AFTER_RST_RELEASE = 8,
    parameter int unsigned PWR_TIMEOUT              = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pwr_rdy,
    input  logic       sw_rst_req,
    input  logic       flag_clr,
    output logic       dom_rst_n,
    output logic       dom_clk_en,
    output logic       busy,
    output logic       rst_flag,
    output logic [1:0] rst_cause,
    output logic       pwr_timeout
);

    localparam int unsigned CNT_W = rcc_cnt_width(RST_DURATION, CLK_ON_AFTER_RST_RELEASE);
    localparam logic [CNT_W-1:0] RST_LD = CNT_W'(RST_DURATION - 1);
    localparam logic [CNT_W-1:0] CLK_LD = CNT_W'(CLK_ON_AFTER_RST_RELEASE - 1);

    // Zero durations cannot be sequenced; such a build elaborates this
    // empty marker block so it is visible in the hierarchy.
    if ((RST_DURATION == 0) || (CLK_ON_AFTER_RST_RELEASE == 0) || (PWR_TIMEOUT == 0))
    begin : g_bad_duration_params
    end

    rcc_state_t       r_state;
    rcc_state_t       w_state_nxt;
    logic             r_dom_rst_n;
    logic             r_dom_clk_en;
    logic             r_busy;
    logic             r_rst_flag;
    logic [1:0]       r_rst_cause;

    logic             w_enter_assert;
    logic [1:0]       w_cause_new;
    logic             w_cnt_load;
    logic [CNT_W-1:0] w_cnt_load_val;
    logic             w_cnt_dec;
    logic             w_cnt_zero_c;

    // Phase counter: holds ASSERT and RELEASE durations.
    rcc_dly_cnt #(
        .W       (CNT_W),
        .RST_VAL ('0)
    ) u_seq_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_dec      (w_cnt_dec),
        .o_zero_c   (w_cnt_zero_c)
    );

    // Next-state and counter control. Loss of power beats everything else;
    // a software request restarts the sequence from any state except HOLD.
    always_comb begin
        w_state_nxt    = r_state;
        w_enter_assert = 1'b0;
        w_cause_new    = RCC_CAUSE_NONE;
        w_cnt_load     = 1'b0;
        w_cnt_load_val = RST_LD;
        w_cnt_dec      = 1'b0;

        if (!pwr_rdy) begin
            w_state_nxt = HOLD;
        end else begin
            unique case (r_state)
                HOLD: begin
                    w_state_nxt    = ASSERT;
                    w_enter_assert = 1'b1;
                    w_cause_new    = RCC_CAUSE_PWR;
                end
                ASSERT: begin
                    if (sw_rst_req) begin
                        w_state_nxt    = ASSERT;
                        w_enter_assert = 1'b1;
                        w_cause_new    = RCC_CAUSE_SW;
                    end else if (w_cnt_zero_c) begin
                        w_state_nxt = GATE;
                    end else begin
                        w_cnt_dec = 1'b1;
                    end
                end
                GATE: begin
                    if (sw_rst_req) begin
                        w_state_nxt    = ASSERT;
                        w_enter_assert = 1'b1;
                        w_cause_new    = RCC_CAUSE_SW;
                    end else begin
                        w_state_nxt    = RELEASE;
                        w_cnt_load     = 1'b1;
                        w_cnt_load_val = CLK_LD;
                    end
                end
                RELEASE: begin
                    if (sw_rst_req) begin
                        w_state_nxt    = ASSERT;
                        w_enter_assert = 1'b1;
                        w_cause_new    = RCC_CAUSE_SW;
                    end else if (w_cnt_zero_c) begin
                        w_state_nxt = RUN;
                    end else begin
                        w_cnt_dec = 1'b1;
                    end
                end
                RUN: begin
                    if (sw_rst_req) begin
                        w_state_nxt    = ASSERT;
                        w_enter_assert = 1'b1;
                        w_cause_new    = RCC_CAUSE_SW;
                    end
                end
                default: begin
                    w_state_nxt = HOLD;
                end
            endcase
        end

        if (w_enter_assert) begin
            w_cnt_load     = 1'b1;
            w_cnt_load_val = RST_LD;
        end
    end

    // State register with outputs decoded from the next state, so each
    // output register always matches the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= HOLD;
            r_dom_rst_n  <= 1'b0;
            r_dom_clk_en <= 1'b0;
            r_busy       <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            {r_dom_rst_n, r_dom_clk_en, r_busy} <= rcc_decode(w_state_nxt);
        end
    end

    // Sticky flag and cause: a new reset in the same cycle as a clear wins
    // and leaves only the new cause.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rst_flag  <= 1'b0;
            r_rst_cause <= RCC_CAUSE_NONE;
        end else if (w_enter_assert) begin
            r_rst_flag  <= 1'b1;
            r_rst_cause <= flag_clr ? w_cause_new : (r_rst_cause | w_cause_new);
        end else if (flag_clr) begin
            r_rst_flag  <= 1'b0;
            r_rst_cause <= RCC_CAUSE_NONE;
        end
    end

`ifdef RCC_RST_SEQ_TIMEOUT_EN
    localparam int unsigned TO_W = (PWR_TIMEOUT <= 1) ? 1 : $clog2(PWR_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LD = TO_W'(PWR_TIMEOUT - 1);

    logic w_in_hold;
    logic w_to_zero_c;
    logic r_pwr_timeout;

    assign w_in_hold = (r_state == HOLD);

    // Reloads on every non-HOLD cycle, so only consecutive HOLD cycles count.
    rcc_dly_cnt #(
        .W       (TO_W),
        .RST_VAL (TO_LD)
    ) u_to_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (!w_in_hold),
        .i_load_val (TO_LD),
        .i_dec      (w_in_hold),
        .o_zero_c   (w_to_zero_c)
    );

    // Sticky timeout; state is not affected.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwr_timeout <= 1'b0;
        end else if (w_in_hold && w_to_zero_c) begin
            r_pwr_timeout <= 1'b1;
        end else if (flag_clr) begin
            r_pwr_timeout <= 1'b0;
        end
    end

    assign pwr_timeout = r_pwr_timeout;
`else
    assign pwr_timeout = 1'b0;
`endif

    assign dom_rst_n  = r_dom_rst_n;
    assign dom_clk_en = r_dom_clk_en;
    assign busy       = r_busy;
    assign rst_flag   = r_rst_flag;
    assign rst_cause  = r_rst_cause;

endmodule : rcc_dom_rst_seq

// File: tb/tb_rcc_dom_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_rcc_dom_rst_seq
// Directed scoreboard bench for rcc_dom_rst_seq. Stimulus drives one edge's
// inputs per call and queues the hand-derived outputs expected after that
// edge; a monitor pops and compares shortly after every rising edge.
// -----------------------------------------------------------------------------
module tb_rcc_dom_rst_seq;

    localparam int unsigned RST_DURATION             = 10;
    localparam int unsigned CLK_ON_AFTER_RST_RELEASE = 8;
    localparam int unsigned PWR_TIMEOUT              = 15;

`ifdef RCC_RST_SEQ_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
`else
    localparam logic TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       pwr_rdy;
    logic       sw_rst_req;
    logic       flag_clr;
    logic       dom_rst_n;
    logic       dom_clk_en;
    logic       busy;
    logic       rst_flag;
    logic [1:0] rst_cause;
    logic       pwr_timeout;

    always #5 clk = ~clk;

    rcc_dom_rst_seq #(
        .RST_DURATION             (RST_DURATION),
        .CLK_ON_AFTER_RST_RELEASE (CLK_ON_AFTER_RST_RELEASE),
        .PWR_TIMEOUT              (PWR_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pwr_rdy     (pwr_rdy),
        .sw_rst_req  (sw_rst_req),
        .flag_clr    (flag_clr),
        .dom_rst_n   (dom_rst_n),
        .dom_clk_en  (dom_clk_en),
        .busy        (busy),
        .rst_flag    (rst_flag),
        .rst_cause   (rst_cause),
        .pwr_timeout (pwr_timeout)
    );

    typedef enum int {S_HOLD, S_ASSERT, S_GATE, S_REL, S_RUN} tb_st_t;

    typedef struct packed {
        logic       rst_n;
        logic       clk_en;
        logic       busy;
        logic       flag;
        logic [1:0] cause;
        logic       to;
    } obs_t;

    typedef struct {
        string name;
        obs_t  exp;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Expected pin pattern for a state plus the flag fields.
    function automatic obs_t mk(input tb_st_t s, input logic flag,
                                input logic [1:0] cause, input logic to);
        obs_t o;
        o.flag  = flag;
        o.cause = cause;
        o.to    = to;
        case (s)
            S_HOLD:   begin o.rst_n = 1'b0; o.clk_en = 1'b0; o.busy = 1'b1; end
            S_ASSERT: begin o.rst_n = 1'b0; o.clk_en = 1'b1; o.busy = 1'b1; end
            S_GATE:   begin o.rst_n = 1'b0; o.clk_en = 1'b0; o.busy = 1'b1; end
            S_REL:    begin o.rst_n = 1'b1; o.clk_en = 1'b0; o.busy = 1'b1; end
            default:  begin o.rst_n = 1'b1; o.clk_en = 1'b1; o.busy = 1'b0; end
        endcase
        return o;
    endfunction

    // One edge: drive inputs at the falling edge, queue the expected result.
    task automatic cyc(input string name, input logic r, input logic p,
                       input logic s, input logic c, input tb_st_t st,
                       input logic flag, input logic [1:0] cause, input logic to);
        exp_t e;
        @(negedge clk);
        rst        = r;
        pwr_rdy    = p;
        sw_rst_req = s;
        flag_clr   = c;
        e.name = name;
        e.exp  = mk(st, flag, cause, to);
        q.push_back(e);
    endtask

    // Remainder of a sequence after the ASSERT-entry edge: n_assert more
    // ASSERT cycles, one GATE, eight RELEASE, then RUN.
    task automatic tail(input string name, input int n_assert, input logic flag,
                        input logic [1:0] cause, input logic to);
        for (int i = 0; i < n_assert; i++)
            cyc({name, "_assert"}, 1'b0, 1'b1, 1'b0, 1'b0, S_ASSERT, flag, cause, to);
        cyc({name, "_gate"}, 1'b0, 1'b1, 1'b0, 1'b0, S_GATE, flag, cause, to);
        for (int i = 0; i < 8; i++)
            cyc({name, "_release"}, 1'b0, 1'b1, 1'b0, 1'b0, S_REL, flag, cause, to);
        cyc({name, "_run"}, 1'b0, 1'b1, 1'b0, 1'b0, S_RUN, flag, cause, to);
    endtask

    // Monitor: compare outputs 1 time unit after each rising edge.
    initial begin : monitor
        exp_t e;
        obs_t a;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                a = {dom_rst_n, dom_clk_en, busy, rst_flag, rst_cause, pwr_timeout};
                vectors++;
                if (a !== e.exp) begin
                    miscompares++;
                    $display("FAIL %s @%0t: rst_n,clk_en,busy,flag,cause,to got %b required %b",
                             e.name, $time, a, e.exp);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst        = 1'b1;
        pwr_rdy    = 1'b0;
        sw_rst_req = 1'b0;
        flag_clr   = 1'b0;

        // Reset values.
        repeat (2) cyc("reset", 1'b1, 1'b0, 1'b0, 1'b0, S_HOLD, 1'b0, 2'b00, 1'b0);

        // No power: HOLD; timeout after 15 HOLD cycles when enabled.
        for (int i = 0; i < 14; i++)
            cyc("hold_nopwr", 1'b0, 1'b0, 1'b0, 1'b0, S_HOLD, 1'b0, 2'b00, 1'b0);
        repeat (2) cyc("hold_timeout", 1'b0, 1'b0, 1'b0, 1'b0, S_HOLD, 1'b0, 2'b00, TO_EN);

        // Power-up: 10 ASSERT, GATE, 8 RELEASE, RUN at cycle 20.
        cyc("pwrup_enter", 1'b0, 1'b1, 1'b0, 1'b0, S_ASSERT, 1'b1, 2'b01, TO_EN);
        tail("pwrup", 9, 1'b1, 2'b01, TO_EN);
        cyc("run_idle", 1'b0, 1'b1, 1'b0, 1'b0, S_RUN, 1'b1, 2'b01, TO_EN);

        // Software reset from RUN: cause accumulates to 11.
        cyc("sw_enter", 1'b0, 1'b1, 1'b1, 1'b0, S_ASSERT, 1'b1, 2'b11, TO_EN);
        tail("sw", 9, 1'b1, 2'b11, TO_EN);

        // Lone clear wipes flag, cause and timeout.
        cyc("clr_lone", 1'b0, 1'b1, 1'b0, 1'b1, S_RUN, 1'b0, 2'b00, 1'b0);
        cyc("run_idle2", 1'b0, 1'b1, 1'b0, 1'b0, S_RUN, 1'b0, 2'b00, 1'b0);

        // Software reset, then a second request in RELEASE cycle 5 restarts.
        cyc("sw2_enter", 1'b0, 1'b1, 1'b1, 1'b0, S_ASSERT, 1'b1, 2'b10, 1'b0);
        for (int i = 0; i < 9; i++)
            cyc("sw2_assert", 1'b0, 1'b1, 1'b0, 1'b0, S_ASSERT, 1'b1, 2'b10, 1'b0);
        cyc("sw2_gate", 1'b0, 1'b1, 1'b0, 1'b0, S_GATE, 1'b1, 2'b10, 1'b0);
        for (int i = 0; i < 5; i++)
            cyc("sw2_release", 1'b0, 1'b1, 1'b0, 1'b0, S_REL, 1'b1, 2'b10, 1'b0);
        cyc("sw2_restart", 1'b0, 1'b1, 1'b1, 1'b0, S_ASSERT, 1'b1, 2'b10, 1'b0);
        tail("sw2_full", 9, 1'b1, 2'b10, 1'b0);

        // Power loss in ASSERT overrides a simultaneous request; restore restarts.
        cyc("sw3_enter", 1'b0, 1'b1, 1'b1, 1'b0, S_ASSERT, 1'b1, 2'b10, 1'b0);
        repeat (2) cyc("sw3_assert", 1'b0, 1'b1, 1'b0, 1'b0, S_ASSERT, 1'b1, 2'b10, 1'b0);
        cyc("pwr_drop", 1'b0, 1'b0, 1'b1, 1'b0, S_HOLD, 1'b1, 2'b10, 1'b0);
        cyc("hold_sw_ign", 1'b0, 1'b0, 1'b1, 1'b0, S_HOLD, 1'b1, 2'b10, 1'b0);
        cyc("hold_wait", 1'b0, 1'b0, 1'b0, 1'b0, S_HOLD, 1'b1, 2'b10, 1'b0);
        cyc("pwr_back", 1'b0, 1'b1, 1'b0, 1'b0, S_ASSERT, 1'b1, 2'b11, 1'b0);
        tail("pwr_back", 9, 1'b1, 2'b11, 1'b0);

        // Clear and request together: set wins, new cause only.
        cyc("clr_and_sw", 1'b0, 1'b1, 1'b1, 1'b1, S_ASSERT, 1'b1, 2'b10, 1'b0);
        repeat (2) cyc("clrsw_assert", 1'b0, 1'b1, 1'b0, 1'b0, S_ASSERT, 1'b1, 2'b10, 1'b0);
        cyc("clr_in_assert", 1'b0, 1'b1, 1'b0, 1'b1, S_ASSERT, 1'b0, 2'b00, 1'b0);
        tail("after_clr", 6, 1'b0, 2'b00, 1'b0);

        // Reset mid-sequence: HOLD and flags cleared, then power-up again.
        cyc("sw4_enter", 1'b0, 1'b1, 1'b1, 1'b0, S_ASSERT, 1'b1, 2'b10, 1'b0);
        repeat (2) cyc("sw4_assert", 1'b0, 1'b1, 1'b0, 1'b0, S_ASSERT, 1'b1, 2'b10, 1'b0);
        cyc("rst_mid", 1'b1, 1'b1, 1'b0, 1'b0, S_HOLD, 1'b0, 2'b00, 1'b0);
        cyc("rst_repwr", 1'b0, 1'b1, 1'b0, 1'b0, S_ASSERT, 1'b1, 2'b01, 1'b0);
        tail("rst_repwr", 9, 1'b1, 2'b01, 1'b0);

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left unchecked, required 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_rcc_dom_rst_seq
